// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: four single-byte RAM reads assembled little-endian; 5 cycles to if_valid without mem_busy.
// Stalls on mem_busy (no issue) and id_stall (holds the presented instruction); jump_enable redirects from any state.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_busy,
  input  logic [7:0]  mem_din,
  output logic        mem_rd,
  output logic [31:0] mem_a,
  input  logic        id_stall,
  input  logic        jump_enable,
  input  logic [31:0] JPC,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic {FETCH, READY} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [2:0]  issue_cnt;
  logic [2:0]  recv_cnt;
  logic        pending;
  logic [23:0] byte_buf;
  logic        issue;

  // rst gates the strobe so the port is quiet the instant reset asserts
  assign issue  = rst && (state == FETCH) && (issue_cnt < 3'd4) && !mem_busy && !jump_enable;
  assign mem_rd = issue;
  assign mem_a  = issue ? (pc + {29'd0, issue_cnt}) : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      pc        <= 32'd0;
      issue_cnt <= 3'd0;
      recv_cnt  <= 3'd0;
      pending   <= 1'b0;
      byte_buf  <= 24'd0;
      if_valid  <= 1'b0;
      if_pc     <= 32'd0;
      if_inst   <= 32'd0;
    end else if (jump_enable) begin
      // a byte in flight from the old stream is dropped by clearing pending
      state     <= FETCH;
      pc        <= JPC;
      issue_cnt <= 3'd0;
      recv_cnt  <= 3'd0;
      pending   <= 1'b0;
      if_valid  <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        issue_cnt <= issue_cnt + 3'd1;
      end
      if (pending) begin
        recv_cnt <= recv_cnt + 3'd1;
        case (recv_cnt[1:0])
          2'd0: byte_buf[7:0]   <= mem_din;
          2'd1: byte_buf[15:8]  <= mem_din;
          2'd2: byte_buf[23:16] <= mem_din;
          2'd3: begin
            if_inst  <= {mem_din, byte_buf};
            if_pc    <= pc;
            if_valid <= 1'b1;
            state    <= READY;
          end
          default: ;
        endcase
      end
      if ((state == READY) && !id_stall) begin
        state     <= FETCH;
        pc        <= pc + 32'd4;
        issue_cnt <= 3'd0;
        recv_cnt  <= 3'd0;
        if_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a byte-count model that reads expected instructions straight from RAM.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_busy;
  logic [7:0]  mem_din;
  logic        mem_rd;
  logic [31:0] mem_a;
  logic        id_stall;
  logic        jump_enable;
  logic [31:0] JPC;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  logic [7:0]  mem [0:4095];
  logic        ram_rd = 1'b0;
  logic [31:0] ram_addr = 32'd0;

  inst_fetch dut (
    .clk(clk), .rst(rst), .mem_busy(mem_busy), .mem_din(mem_din),
    .mem_rd(mem_rd), .mem_a(mem_a), .id_stall(id_stall),
    .jump_enable(jump_enable), .JPC(JPC), .if_valid(if_valid),
    .if_pc(if_pc), .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem[12'(a + 32'd3)], mem[12'(a + 32'd2)], mem[12'(a + 32'd1)], mem[12'(a)]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget, output int cycles);
    cycles = 0;
    while (!if_valid && cycles < budget) begin
      cyc();
      @(negedge clk);
      cycles++;
    end
    chk(name, 32'(if_valid), 32'd1);
  endtask

  // RAM: one byte per read, returned the cycle after the address; junk otherwise
  initial forever begin
    @(negedge clk);
    ram_rd   = mem_rd;
    ram_addr = mem_a;
  end

  initial begin
    mem_din = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      mem_din = ram_rd ? mem[ram_addr[11:0]] : 8'($urandom);
    end
  end

  // Reference: an instruction is four bytes at the current pc; track how many
  // have been requested and returned, and present the RAM word once all four are back.
  initial begin
    logic [31:0] m_pc;
    int          m_issued;
    int          m_got;
    bit          m_inflight;
    bit          m_present;
    bit          exp_rd;
    logic [31:0] exp_a;
    m_pc = 0; m_issued = 0; m_got = 0; m_inflight = 0; m_present = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (!rst) begin
        m_pc = 0; m_issued = 0; m_got = 0; m_inflight = 0; m_present = 0;
        chk("m_rst_rd", 32'(mem_rd), 32'd0);
        chk("m_rst_addr", mem_a, 32'd0);
        chk("m_rst_valid", 32'(if_valid), 32'd0);
        chk("m_rst_pc", if_pc, 32'd0);
        chk("m_rst_inst", if_inst, 32'd0);
      end else begin
        exp_rd = !m_present && (m_issued < 4) && !mem_busy && !jump_enable;
        exp_a  = exp_rd ? m_pc + 32'(m_issued) : 32'd0;
        chk("m_rd", 32'(mem_rd), 32'(exp_rd));
        chk("m_addr", mem_a, exp_a);
        chk("m_valid", 32'(if_valid), 32'(m_present));
        if (m_present) begin
          chk("m_pc", if_pc, m_pc);
          chk("m_inst", if_inst, word_at(m_pc));
        end
        if (jump_enable) begin
          m_pc = JPC; m_issued = 0; m_got = 0; m_inflight = 0; m_present = 0;
        end else if (m_present) begin
          if (!id_stall) begin
            m_present = 0; m_pc = m_pc + 32'd4; m_issued = 0; m_got = 0;
          end
        end else begin
          if (m_inflight) m_got++;
          m_inflight = exp_rd;
          if (exp_rd) m_issued++;
          if (m_got == 4) m_present = 1;
        end
      end
    end
  end

  initial begin
    int n;
    int r;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    mem[12'h100] = 8'hA5;

    // reset with noisy inputs that must be ignored
    rst = 1'b0; mem_busy = 1'b1; id_stall = 1'b0; jump_enable = 1'b1; JPC = 32'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_addr", mem_a, 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);

    // first fetch from 0
    cyc(); rst = 1'b1; mem_busy = 1'b0; jump_enable = 1'b0; id_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t1_rd", 32'(mem_rd), 32'd1);
      chk("t1_addr", mem_a, 32'(c));
      cyc();
    end
    @(negedge clk);
    chk("t1_early", 32'(if_valid), 32'd0);
    chk("t1_rd4", 32'(mem_rd), 32'd0);
    cyc();
    @(negedge clk);
    chk("t1_valid", 32'(if_valid), 32'd1);
    chk("t1_inst", if_inst, 32'h00100513);
    chk("t1_pc", if_pc, 32'd0);

    // decode stall holds the instruction
    repeat (2) begin
      cyc();
      @(negedge clk);
      chk("t2_valid", 32'(if_valid), 32'd1);
      chk("t2_inst", if_inst, 32'h00100513);
      chk("t2_pc", if_pc, 32'd0);
      chk("t2_rd", 32'(mem_rd), 32'd0);
    end
    cyc(); id_stall = 1'b0;
    @(negedge clk);
    chk("t2_xfer_valid", 32'(if_valid), 32'd1);
    cyc();
    @(negedge clk);
    chk("t2_next_valid", 32'(if_valid), 32'd0);
    chk("t2_next_addr", mem_a, 32'd4);
    wait_valid("t2_wait", 20, n);
    chk("t2_lat", 32'(n), 32'd5);
    chk("t2_pc4", if_pc, 32'd4);

    // memory busy for two cycles of the fetch at 8
    cyc();
    @(negedge clk);
    chk("t3_addr0", mem_a, 32'd8);
    cyc(); mem_busy = 1'b1;
    @(negedge clk);
    chk("t3_busy1", 32'(mem_rd), 32'd0);
    cyc();
    @(negedge clk);
    chk("t3_busy2", 32'(mem_rd), 32'd0);
    cyc(); mem_busy = 1'b0;
    @(negedge clk);
    chk("t3_addr1", mem_a, 32'd9);
    wait_valid("t3_wait", 20, n);
    chk("t3_lat", 32'(n), 32'd4);
    chk("t3_pc", if_pc, 32'd8);
    chk("t3_inst", if_inst, word_at(32'd8));

    // redirect after two bytes of the fetch at 12
    cyc();
    @(negedge clk);
    chk("t4_addr0", mem_a, 32'd12);
    cyc();
    @(negedge clk);
    chk("t4_addr1", mem_a, 32'd13);
    cyc(); jump_enable = 1'b1; JPC = 32'h100;
    @(negedge clk);
    chk("t4_jmp_rd", 32'(mem_rd), 32'd0);
    cyc(); jump_enable = 1'b0; id_stall = 1'b1;
    @(negedge clk);
    chk("t4_tgt", mem_a, 32'h100);
    wait_valid("t4_wait", 20, n);
    chk("t4_lat", 32'(n), 32'd5);
    chk("t4_pc", if_pc, 32'h100);
    chk("t4_inst", if_inst, word_at(32'h100));

    // redirect wins over transfer
    cyc(); id_stall = 1'b0; jump_enable = 1'b1; JPC = 32'h40;
    @(negedge clk);
    chk("t5_hold", 32'(if_valid), 32'd1);
    cyc(); jump_enable = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(if_valid), 32'd0);
    chk("t5_addr", mem_a, 32'h40);

    // asynchronous reset in the middle of the fetch at 8
    cyc(); jump_enable = 1'b1; JPC = 32'd8;
    @(negedge clk);
    cyc(); jump_enable = 1'b0;
    @(negedge clk);
    chk("t6_addr0", mem_a, 32'd8);
    cyc();
    @(negedge clk);
    chk("t6_addr1", mem_a, 32'd9);
    chk("t6_pc_before", if_pc, 32'h100);
    cyc();
    #2 rst = 1'b0;
    #1;
    chk("t6_rd", 32'(mem_rd), 32'd0);
    chk("t6_addr", mem_a, 32'd0);
    chk("t6_valid", 32'(if_valid), 32'd0);
    chk("t6_pc", if_pc, 32'd0);
    chk("t6_inst", if_inst, 32'd0);
    cyc(); rst = 1'b1;
    @(negedge clk);
    chk("t6_restart_rd", 32'(mem_rd), 32'd1);
    chk("t6_restart_addr", mem_a, 32'd0);
    wait_valid("t6_wait", 20, n);
    chk("t6_lat", 32'(n), 32'd5);
    chk("t6_refetch_pc", if_pc, 32'd0);
    chk("t6_refetch_inst", if_inst, 32'h00100513);

    // randomized traffic, including wrap-around targets and reset pulses
    for (int i = 0; i < 4000; i++) begin
      cyc();
      rst         = 1'b1;
      mem_busy    = ($urandom_range(0, 3) == 0);
      id_stall    = ($urandom_range(0, 9) < 3);
      jump_enable = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 3);
      JPC = (r == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b0;
      end
    end

    cyc();
    done = 1'b1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
